// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32 x 32-bit architectural register file with two
// combinational read ports, one write port, and a single-entry scoreboard
// that tracks the destination of an in-flight multiply/divide.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write port
// data to a read port addressing the register being written in the
// same cycle. Without it, reads return the stored array contents.
module regfile_scoreboard (
    input  logic        clock,
    input  logic        reset,
    input  logic        wE,
    input  logic [4:0]  writeD,
    input  logic [31:0] writeData,
    input  logic        multOrDivReady,
    input  logic [4:0]  readA,
    input  logic [4:0]  readB,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    input  logic        mdStart,
    input  logic [4:0]  mdDest,
    output logic        stall,
    output logic        mdBusy,
    output logic        mdOverlap
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic        busy_q;
    logic        busy_d;
    logic [4:0]  dest_q;
    logic [4:0]  dest_d;
    logic        overlap_q;
    logic        overlap_d;

    logic        write_ok;
    logic        md_clear;

    assign write_ok = wE && (writeD != '0);
    assign md_clear = wE && multOrDivReady && busy_q;

    // Next register-array contents: apply the current write, r0 stays zero.
    always_comb begin
        regs_d = regs_q;
        if (write_ok) begin
            regs_d[writeD] = writeData;
        end
        regs_d[0] = '0;
    end

    // Register array storage with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Scoreboard next state: completion clears, a new issue sets (and wins
    // over a same-edge clear), an issue while still busy is dropped and
    // latched as a sticky overlap error.
    always_comb begin
        busy_d    = busy_q;
        dest_d    = dest_q;
        overlap_d = overlap_q;
        if (md_clear) begin
            busy_d = 1'b0;
        end
        if (mdStart) begin
            if (busy_q && !md_clear) begin
                overlap_d = 1'b1;
            end else if (mdDest != '0) begin
                busy_d = 1'b1;
                dest_d = mdDest;
            end
        end
    end

    // Scoreboard state registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            dest_q    <= '0;
            overlap_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            dest_q    <= dest_d;
            overlap_q <= overlap_d;
        end
    end

    // Read ports: r0 reads zero; optional write-through forwarding.
    always_comb begin
        dataA = (readA == '0) ? '0 : regs_q[readA];
        dataB = (readB == '0) ? '0 : regs_q[readB];
`ifdef REGFILE_BYPASS_EN
        if (write_ok && (readA == writeD)) begin
            dataA = writeData;
        end
        if (write_ok && (readB == writeD)) begin
            dataB = writeData;
        end
`endif
    end

    // Hazard detection against the pending multdiv destination.
    always_comb begin
        stall     = busy_q && ((readA == dest_q) || (readB == dest_q));
        mdBusy    = busy_q;
        mdOverlap = overlap_q;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run against a behavioural model (array + pending-op queue).
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wE = 1'b0;
    logic [4:0]  writeD = '0;
    logic [31:0] writeData = '0;
    logic        multOrDivReady = 1'b0;
    logic [4:0]  readA = '0;
    logic [4:0]  readB = '0;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        mdStart = 1'b0;
    logic [4:0]  mdDest = '0;
    logic        stall;
    logic        mdBusy;
    logic        mdOverlap;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic [4:0]  m_pend [$];
    logic        m_overlap;

    regfile_scoreboard dut (
        .clock(clock), .reset(reset), .wE(wE), .writeD(writeD),
        .writeData(writeData), .multOrDivReady(multOrDivReady),
        .readA(readA), .readB(readB), .dataA(dataA), .dataB(dataB),
        .mdStart(mdStart), .mdDest(mdDest), .stall(stall),
        .mdBusy(mdBusy), .mdOverlap(mdOverlap)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pend.delete();
        m_overlap = 1'b0;
    endfunction

    function automatic void model_edge();
        bit was_busy = (m_pend.size() != 0);
        bit completing = wE && multOrDivReady && was_busy;
        if (wE && writeD != 0) m_regs[writeD] = writeData;
        if (completing) m_pend.delete();
        if (mdStart) begin
            if (was_busy && !completing) m_overlap = 1'b1;
            else if (mdDest != 0) m_pend.push_back(mdDest);
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wE && writeD == a) return writeData;
`endif
        return m_regs[a];
    endfunction

    function automatic logic model_stall();
        if (m_pend.size() == 0) return 1'b0;
        return (readA == m_pend[0]) || (readB == m_pend[0]);
    endfunction

    task automatic idle_inputs();
        wE = 0; writeD = 0; writeData = 0; multOrDivReady = 0;
        mdStart = 0; mdDest = 0;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            readA = 5'(i); readB = 5'(31 - i);
            #1;
            n_cmp++;
            if (dataA !== 32'h0 || dataB !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read addr=%0d got A=%h B=%h want 0/0", i, dataA, dataB);
            end
        end
        n_cmp++;
        if (stall !== 1'b0 || mdBusy !== 1'b0 || mdOverlap !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags got stall=%b busy=%b ovl=%b want 0/0/0", stall, mdBusy, mdOverlap);
        end
        @(negedge clock);
        reset = 0;
        model_reset();
        #2;
    endtask

    task automatic test_write_read();
        wE = 1; writeD = 5; writeData = 32'hDEADBEEF;
        cycle();
        idle_inputs(); readA = 5; readB = 0;
        #1;
        n_cmp++;
        if (dataA !== 32'hDEADBEEF || dataB !== 32'h0) begin
            n_err++;
            $display("FAIL write_r5 got A=%h B=%h want deadbeef/0", dataA, dataB);
        end
        wE = 1; writeD = 0; writeData = 32'hFFFFFFFF;
        cycle();
        idle_inputs(); readA = 0; readB = 5;
        #1;
        n_cmp++;
        if (dataA !== 32'h0 || dataB !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_r0 got A=%h B=%h want 0/deadbeef", dataA, dataB);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
`ifdef REGFILE_BYPASS_EN
        exp = 32'h12345678;
`else
        exp = 32'h0;
`endif
        wE = 1; writeD = 7; writeData = 32'h12345678; readA = 0; readB = 7;
        #1;
        n_cmp++;
        if (dataB !== exp) begin
            n_err++;
            $display("FAIL bypass_same_cycle got %h want %h", dataB, exp);
        end
        cycle();
        idle_inputs();
        #1;
        n_cmp++;
        if (dataB !== 32'h12345678) begin
            n_err++;
            $display("FAIL bypass_next_cycle got %h want 12345678", dataB);
        end
    endtask

    task automatic test_scoreboard();
        mdStart = 1; mdDest = 9;
        cycle();
        idle_inputs(); readA = 9; readB = 0;
        #1;
        n_cmp++;
        if (stall !== 1'b1 || mdBusy !== 1'b1) begin
            n_err++;
            $display("FAIL md_pending got stall=%b busy=%b want 1/1", stall, mdBusy);
        end
        wE = 1; multOrDivReady = 1; writeD = 9; writeData = 32'h40;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL md_completing_stall got %b want 1", stall);
        end
        cycle();
        idle_inputs();
        #1;
        n_cmp++;
        if (stall !== 1'b0 || mdBusy !== 1'b0 || dataA !== 32'h40) begin
            n_err++;
            $display("FAIL md_done got stall=%b busy=%b A=%h want 0/0/00000040", stall, mdBusy, dataA);
        end
    endtask

    task automatic test_same_edge();
        readA = 0; readB = 0;
        mdStart = 1; mdDest = 9;
        cycle();
        idle_inputs();
        wE = 1; multOrDivReady = 1; writeD = 9; writeData = 32'h99;
        mdStart = 1; mdDest = 3;
        cycle();
        idle_inputs(); readB = 3;
        #1;
        n_cmp++;
        if (mdBusy !== 1'b1 || stall !== 1'b1) begin
            n_err++;
            $display("FAIL same_edge_r3 got busy=%b stall=%b want 1/1", mdBusy, stall);
        end
        readB = 9;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL same_edge_r9 got stall=%b want 0", stall);
        end
        mdStart = 1; mdDest = 12;
        cycle();
        idle_inputs(); readB = 12;
        #1;
        n_cmp++;
        if (mdOverlap !== 1'b1 || stall !== 1'b0 || mdBusy !== 1'b1) begin
            n_err++;
            $display("FAIL overlap got ovl=%b stall=%b busy=%b want 1/0/1", mdOverlap, stall, mdBusy);
        end
        readB = 3;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL overlap_entry_kept got stall=%b want 1", stall);
        end
        wE = 1; multOrDivReady = 1; writeD = 3; writeData = 32'h33;
        cycle();
        idle_inputs();
        #1;
        n_cmp++;
        if (mdBusy !== 1'b0 || mdOverlap !== 1'b1) begin
            n_err++;
            $display("FAIL overlap_sticky got busy=%b ovl=%b want 0/1", mdBusy, mdOverlap);
        end
    endtask

    task automatic test_async_reset();
        readA = 0; readB = 0;
        wE = 1; writeD = 4; writeData = 32'h5555;
        mdStart = 1; mdDest = 4;
        cycle();
        idle_inputs(); readA = 4;
        #2;
        reset = 1;
        #1;
        model_reset();
        n_cmp++;
        if (mdBusy !== 1'b0 || stall !== 1'b0 || mdOverlap !== 1'b0 || dataA !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset got busy=%b stall=%b ovl=%b A=%h want 0/0/0/0", mdBusy, stall, mdOverlap, dataA);
        end
        #1;
        reset = 0;
        wE = 1; multOrDivReady = 1; writeD = 4; writeData = 32'hABCD;
        cycle();
        idle_inputs(); readA = 4;
        #1;
        n_cmp++;
        if (dataA !== 32'hABCD || mdBusy !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_write got A=%h busy=%b stall=%b want 0000abcd/0/0", dataA, mdBusy, stall);
        end
    endtask

    task automatic test_random();
        logic [31:0] ea, eb;
        logic        es;
        for (int n = 0; n < 400; n++) begin
            wE = ($urandom_range(0, 3) != 0);
            writeD = 5'($urandom_range(0, 31));
            writeData = $urandom;
            multOrDivReady = ($urandom_range(0, 3) == 0);
            mdStart = ($urandom_range(0, 4) == 0);
            mdDest = 5'($urandom_range(0, 31));
            readA = ($urandom_range(0, 3) == 0) ? writeD : 5'($urandom_range(0, 31));
            readB = (m_pend.size() != 0 && $urandom_range(0, 2) == 0) ? m_pend[0]
                                                                      : 5'($urandom_range(0, 31));
            #1;
            ea = model_read(readA);
            eb = model_read(readB);
            es = model_stall();
            n_cmp++;
            if (dataA !== ea || dataB !== eb) begin
                n_err++;
                $display("FAIL rand_read[%0d] ra=%0d rb=%0d got %h/%h want %h/%h", n, readA, readB, dataA, dataB, ea, eb);
            end
            n_cmp++;
            if (stall !== es || mdBusy !== (m_pend.size() != 0) || mdOverlap !== m_overlap) begin
                n_err++;
                $display("FAIL rand_sb[%0d] got stall=%b busy=%b ovl=%b want %b/%b/%b", n, stall, mdBusy, mdOverlap,
                         es, (m_pend.size() != 0), m_overlap);
            end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        #3;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_same_edge();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
